// File: rtl/rtc_pkg.sv
// Shared RTC types and constants.
// Used by the echo path and, later, by the Avalon register block.
package rtc_pkg;

    localparam int TIME_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TX,
        BLANK,
        LISTEN,
        QUALIFY,
        HOLDOFF
    } echo_state_t;

    // Word offsets for the echo detector on the Avalon slave
    localparam logic [3:0] ECHO_CTRL_OFS     = 4'h0;
    localparam logic [3:0] ECHO_STATUS_OFS   = 4'h1;
    localparam logic [3:0] ECHO_BLANK_OFS    = 4'h2;
    localparam logic [3:0] ECHO_WIDTH_OFS    = 4'h3;
    localparam logic [3:0] ECHO_HOLDOFF_OFS  = 4'h4;
    localparam logic [3:0] ECHO_LISTEN_OFS   = 4'h5;
    localparam logic [3:0] ECHO_TIME_OFS     = 4'h6;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin.
// rise is high in the first cycle the synchronised level reads 1.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic sync,
    output logic sync_d,
    output logic rise
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain  <= '0;
            sync_d <= 1'b0;
        end else begin
            chain  <= {chain[STAGES-2:0], d};
            sync_d <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~sync_d;

endmodule

// File: rtl/echo_event_detector.sv
// Echo receive conditioning: sync, blanking, glitch filter,
// single-cycle event pulse and latency-compensated timestamp.
module echo_event_detector
    import rtc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              echo_in,
    input  logic              piezo_enable,
    input  logic [TIME_W-1:0] time_cnt,
    input  logic              arm,
    input  logic              abort,
    input  logic [CNT_W-1:0]  blank_cycles,
    input  logic [7:0]        min_width,
    input  logic [CNT_W-1:0]  holdoff_cycles,
    input  logic [23:0]       listen_cycles,
    output logic              event_trigger,
    output logic [TIME_W-1:0] event_time,
    output logic              event_valid,
    output logic              timeout,
    output logic              busy
);

    echo_state_t state, state_nx;

    logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
    logic [23:0]       tcnt, tcnt_nx, tcnt_inc;
    logic [7:0]        qcnt, qcnt_nx, qcnt_inc, width;
    logic [TIME_W-1:0] cap, cap_nx, etime_nx, ev_src;
    logic              trig_nx, valid_nx, tout_nx;
    logic              sync, sync_d, rise;
    logic              piezo_d, pz_rise;
    logic              tmo, fire, expire;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock  (clock),
        .reset  (reset),
        .d      (echo_in),
        .sync   (sync),
        .sync_d (sync_d),
        .rise   (rise)
    );

    assign pz_rise  = piezo_enable & ~piezo_d;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign tcnt_inc = tcnt + 24'd1;
    assign qcnt_inc = qcnt + 8'd1;
    assign width    = (min_width == 8'd0) ? 8'd1 : min_width;
    assign tmo      = (listen_cycles != 24'd0) &&
                      (tcnt_inc == listen_cycles);
    // with a width of 1 the echo qualifies in its rise cycle
    assign ev_src   = (state == LISTEN) ? time_cnt : cap;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tcnt_nx  = tcnt;
        qcnt_nx  = qcnt;
        cap_nx   = cap;
        trig_nx  = 1'b0;
        etime_nx = event_time;
        valid_nx = event_valid;
        tout_nx  = timeout;
        fire     = 1'b0;
        expire   = 1'b0;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arm) begin
                        valid_nx = 1'b0;
                        tout_nx  = 1'b0;
                        state_nx = WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (pz_rise) begin
                        cnt_nx   = '0;
                        tcnt_nx  = '0;
                        state_nx = (blank_cycles != '0) ? BLANK : LISTEN;
                    end
                end
                BLANK: begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == blank_cycles) state_nx = LISTEN;
                end
                LISTEN: begin
                    tcnt_nx = tcnt_inc;
                    if (rise && width == 8'd1) begin
                        fire = 1'b1;
                    end else if (tmo) begin
                        expire = 1'b1;
                    end else if (rise) begin
                        cap_nx   = time_cnt;
                        qcnt_nx  = 8'd1;
                        state_nx = QUALIFY;
                    end
                end
                QUALIFY: begin
                    tcnt_nx = tcnt_inc;
                    if (sync && qcnt_inc == width) begin
                        fire = 1'b1;
                    end else if (tmo) begin
                        expire = 1'b1;
                    end else if (!sync) begin
                        state_nx = LISTEN;
                    end else begin
                        qcnt_nx = qcnt_inc;
                    end
                end
                HOLDOFF: begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc >= holdoff_cycles) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
            if (fire) begin
                trig_nx  = 1'b1;
                etime_nx = ev_src - TIME_W'(SYNC_STAGES);
                valid_nx = 1'b1;
                cnt_nx   = '0;
                state_nx = HOLDOFF;
            end
            if (expire) begin
                tout_nx  = 1'b1;
                cnt_nx   = '0;
                state_nx = HOLDOFF;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            tcnt          <= '0;
            qcnt          <= '0;
            cap           <= '0;
            piezo_d       <= 1'b0;
            event_trigger <= 1'b0;
            event_time    <= '0;
            event_valid   <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            tcnt          <= tcnt_nx;
            qcnt          <= qcnt_nx;
            cap           <= cap_nx;
            piezo_d       <= piezo_enable;
            event_trigger <= trig_nx;
            event_time    <= etime_nx;
            event_valid   <= valid_nx;
            timeout       <= tout_nx;
        end
    end

endmodule

// File: tb/tb_echo_event_detector.sv
// Scoreboard bench for echo_event_detector: randomized echo
// waveforms against a rule-level reference model.
module tb_echo_event_detector;

    localparam int SS = 2;

    typedef enum int {K_EV, K_TO, K_BR, K_BF} kind_t;
    typedef struct {
        kind_t       k;
        int          c;
        logic [31:0] t;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        echo_in = 1'b0;
    logic        piezo_enable = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] time_cnt;
    logic [15:0] blank_cycles = '0;
    logic [7:0]  min_width = '0;
    logic [15:0] holdoff_cycles = '0;
    logic [23:0] listen_cycles = '0;
    logic        event_trigger;
    logic [31:0] event_time;
    logic        event_valid;
    logic        timeout;
    logic        busy;

    int          cyc = 0;
    logic [31:0] tbase = '0;
    int          vecs = 0;
    int          errs = 0;
    exp_t        sbq[$];
    bit          eq[$];
    logic [31:0] last_time = '0;
    logic        last_valid = 1'b0;
    logic        last_to = 1'b0;
    logic        busy_q = 1'b0;
    logic        to_q = 1'b0;

    echo_event_detector #(
        .SYNC_STAGES (SS),
        .CNT_W       (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .echo_in        (echo_in),
        .piezo_enable   (piezo_enable),
        .time_cnt       (time_cnt),
        .arm            (arm),
        .abort          (abort),
        .blank_cycles   (blank_cycles),
        .min_width      (min_width),
        .holdoff_cycles (holdoff_cycles),
        .listen_cycles  (listen_cycles),
        .event_trigger  (event_trigger),
        .event_time     (event_time),
        .event_valid    (event_valid),
        .timeout        (timeout),
        .busy           (busy)
    );

    always #10 clock = ~clock;

    always @(posedge clock) begin
        #1;
        cyc = cyc + 1;
    end

    assign time_cnt = tbase + 32'(cyc);

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic push(input kind_t k, input int c,
                        input logic [31:0] t);
        exp_t e;
        e.k = k;
        e.c = c;
        e.t = t;
        sbq.push_back(e);
    endtask

    task automatic mon(input string nm, input kind_t k,
                       input logic [31:0] t);
        exp_t e;
        vecs++;
        if (sbq.size() == 0) begin
            errs++;
            $display("FAIL %s: unexpected at cycle %0d time %h, want none",
                     nm, cyc, t);
        end else begin
            e = sbq.pop_front();
            if (e.k != k || e.c != cyc || (k == K_EV && e.t !== t)) begin
                errs++;
                $display("FAIL %s: got cycle %0d time %h, want %s cycle %0d time %h",
                         nm, cyc, t, e.k.name(), e.c, e.t);
            end
        end
    endtask

    always @(negedge clock) begin
        if (event_trigger) mon("event", K_EV, event_time);
        if (timeout && !to_q) mon("timeout", K_TO, 32'd0);
        if (busy && !busy_q) mon("busy_rise", K_BR, 32'd0);
        if (!busy && busy_q) mon("busy_fall", K_BF, 32'd0);
        to_q   = timeout;
        busy_q = busy;
    end

    function automatic bit sy(input bit e[$], input int k);
        int j;
        j = k - SS;
        return (j >= 0 && j < e.size()) ? e[j] : 1'b0;
    endfunction

    task automatic clr();
        eq.delete();
    endtask

    task automatic pulse(input int from, input int len);
        for (int j = from; j < from + len; j++) begin
            while (eq.size() <= j) eq.push_back(1'b0);
            eq[j] = 1'b1;
        end
    endtask

    // k is the cycle offset from the arm pulse; sync(k) = echo(k-SS)
    task automatic run_trial(input string nm, input int blank,
                             input int mw, input int hold,
                             input int listen, input logic [31:0] toff,
                             input int pz, input bit e[$],
                             input int x_arm, input int x_pz);
        int a, ls, w, h, k, ek, hd, kend;
        bit q, isev, s, sp;
        logic [31:0] etime;
        a = cyc + 3;
        at(a - 1);
        blank_cycles   = 16'(blank);
        min_width      = 8'(mw);
        holdoff_cycles = 16'(hold);
        listen_cycles  = 24'(listen);
        tbase          = toff - 32'(a);
        ls   = pz + 1 + blank;
        w    = (mw == 0) ? 1 : mw;
        h    = -1;
        q    = 1'b0;
        isev = 1'b0;
        ek   = 0;
        k    = ls;
        while (h < 0 && k < ls + 20000) begin
            s  = sy(e, k);
            sp = sy(e, k - 1);
            if (!q) begin
                if (s && !sp) begin
                    q  = 1'b1;
                    ek = k;
                end
            end else if (!s) begin
                q = 1'b0;
            end
            if (q && (k - ek + 1) == w) begin
                h    = k + 1;
                isev = 1'b1;
            end else if (listen != 0 && (k - ls + 1) == listen) begin
                h = k + 1;
            end
            k++;
        end
        if (h < 0) begin
            $display("FAIL %s: reference model found no outcome", nm);
            $fatal(1);
        end
        hd    = (hold == 0) ? 1 : hold;
        etime = toff + 32'(ek) - 32'(SS);
        push(K_BR, a + 1, 32'd0);
        if (isev) push(K_EV, a + h, etime);
        else push(K_TO, a + h, 32'd0);
        push(K_BF, a + h + hd, 32'd0);
        kend = (e.size() + 2 > h + hd + 2) ? e.size() + 2 : h + hd + 2;
        for (int i = 0; i <= kend; i++) begin
            at(a + i);
            arm          = (i == 0) || (i == x_arm);
            piezo_enable = (i == pz) || (i == pz + 1) ||
                           (x_pz >= 0 && (i == x_pz || i == x_pz + 1));
            echo_in      = (i < e.size()) ? e[i] : 1'b0;
        end
        arm          = 1'b0;
        piezo_enable = 1'b0;
        echo_in      = 1'b0;
        if (isev) last_time = etime;
        last_valid = isev;
        last_to    = !isev;
        chk({nm, "_valid"}, event_valid, last_valid);
        chk({nm, "_timeout"}, timeout, last_to);
        chk({nm, "_time"}, event_time, last_time);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, j, len, blank, pz;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_trigger", event_trigger, 0);
        chk("rst_time", event_time, 0);
        chk("rst_valid", event_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_busy", busy, 0);

        clr();
        pulse(302, 20);
        run_trial("basic", 100, 4, 3, 0, 32'h0000_1000, 2, eq, -1, -1);

        clr();
        for (int i = 2; i < 98; i++) if (((i / 2) % 2) == 1) pulse(i, 1);
        pulse(151, 20);
        run_trial("blanking", 100, 4, 2, 0, 32'h00AB_0000, 1, eq, -1, -1);

        clr();
        pulse(30, 3);
        pulse(50, 10);
        run_trial("glitch", 5, 4, 1, 200, 32'h1234_5678, 1, eq, -1, -1);

        clr();
        run_trial("tmo", 10, 4, 7, 500, 32'h0, 1, eq, -1, -1);

        clr();
        pulse(20, 11);
        run_trial("wrap", 0, 0, 0, 0, 32'hFFFF_FFEB, 1, eq, -1, -1);
        chk("wrap_value", event_time, 32'hFFFF_FFFF);

        // listen_cycles = 0 never times out; leave via abort
        a = cyc + 3;
        at(a - 1);
        blank_cycles   = 16'd5;
        min_width      = 8'd4;
        holdoff_cycles = 16'd0;
        listen_cycles  = 24'd0;
        push(K_BR, a + 1, 32'd0);
        push(K_BF, a + 601, 32'd0);
        at(a);
        arm = 1'b1;
        at(a + 1);
        arm = 1'b0;
        at(a + 2);
        piezo_enable = 1'b1;
        at(a + 4);
        piezo_enable = 1'b0;
        at(a + 600);
        chk("listen0_busy", busy, 1);
        abort = 1'b1;
        at(a + 601);
        abort = 1'b0;
        at(a + 604);
        chk("listen0_valid", event_valid, 0);
        chk("listen0_timeout", timeout, 0);
        chk("listen0_time", event_time, last_time);

        clr();
        pulse(4, 12);
        run_trial("w3", 0, 3, 2, 0, 32'h7777_0000, 1, eq, 2, 10);

        // abort while qualifying: rise at k=12, abort at k=15
        a = cyc + 3;
        at(a - 1);
        blank_cycles   = 16'd0;
        min_width      = 8'd8;
        holdoff_cycles = 16'd2;
        listen_cycles  = 24'd0;
        push(K_BR, a + 1, 32'd0);
        push(K_BF, a + 16, 32'd0);
        for (int i = 0; i <= 45; i++) begin
            at(a + i);
            arm          = (i == 0);
            piezo_enable = (i == 1) || (i == 2);
            echo_in      = (i >= 10 && i <= 40);
            abort        = (i == 15);
        end
        chk("abort_valid", event_valid, 0);
        chk("abort_timeout", timeout, 0);
        chk("abort_time", event_time, last_time);

        clr();
        pulse(10, 6);
        run_trial("pre_rst", 3, 2, 1, 0, 32'hCAFE_0000, 1, eq, -1, -1);

        // asynchronous reset in the middle of BLANK
        a = cyc + 3;
        at(a - 1);
        blank_cycles   = 16'd100;
        min_width      = 8'd2;
        holdoff_cycles = 16'd0;
        listen_cycles  = 24'd0;
        push(K_BR, a + 1, 32'd0);
        push(K_BF, a + 21, 32'd0);
        at(a);
        arm = 1'b1;
        at(a + 1);
        arm = 1'b0;
        piezo_enable = 1'b1;
        at(a + 3);
        piezo_enable = 1'b0;
        at(a + 20);
        #2 reset = 1'b1;
        #1;
        chk("arst_trigger", event_trigger, 0);
        chk("arst_time", event_time, 0);
        chk("arst_valid", event_valid, 0);
        chk("arst_timeout", timeout, 0);
        chk("arst_busy", busy, 0);
        at(a + 23);
        reset      = 1'b0;
        last_time  = '0;
        last_valid = 1'b0;
        last_to    = 1'b0;

        clr();
        pulse(40, 10);
        run_trial("restart", 20, 4, 0, 300, 32'h0BAD_F00D, 1, eq, -1, -1);

        for (int n = 0; n < 40; n++) begin
            clr();
            j = 0;
            while (j < 150) begin
                j   = j + int'($urandom_range(1, 15));
                len = int'($urandom_range(1, 8));
                if (j < 150) pulse(j, (j + len > 150) ? 150 - j : len);
                j = j + len;
            end
            pulse(160, 16);
            blank = int'($urandom_range(0, 40));
            pz    = int'($urandom_range(1, 4));
            run_trial("rand", blank, int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 5)),
                      ($urandom_range(0, 3) == 0) ? 0 :
                          int'($urandom_range(20, 150)),
                      $urandom, pz, eq,
                      ($urandom_range(0, 1) == 1) ? 2 : -1,
                      ($urandom_range(0, 1) == 1) ?
                          pz + 1 + blank + int'($urandom_range(1, 10)) : -1);
        end

        repeat (5) @(negedge clock);
        chk("scoreboard_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
